// File: rtl/zxn_reset_seq.sv
// zxn_reset_seq: orders hard/mount/soft resets and clears memory during hard reset
module zxn_reset_seq #(
    parameter int         AW       = 21,
    parameter logic [7:0] CLR_VAL  = 8'hFF,
    parameter int         HOLD_CYC = 1024,
    parameter int         POST_CYC = 16,
    parameter int         SOFT_CYC = 64,
    parameter bit         CLR_EN   = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          req_hard,
    input  logic          req_mount,
    input  logic          mount_rst_en,
    input  logic          req_soft,
    input  logic          clr_ack,
    output logic          hard_reset,
    output logic          soft_reset,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic [7:0]    clr_data,
    output logic          busy
);
    localparam int HP = HOLD_CYC > POST_CYC ? HOLD_CYC : POST_CYC;
    localparam int MX = HP > SOFT_CYC ? HP : SOFT_CYC;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;

    typedef enum logic [2:0] {IDLE, HOLD, CLEAR, POST, SOFT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          hard_in_q, mount_in_q, soft_in_q;
    logic          hard_evt_q, soft_evt_q;
    logic          hard_reset_q, soft_reset_q, clr_we_q, busy_q;

    // Sample each request once and register its rising edge as a one-cycle event
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hard_in_q  <= 1'b0;
            mount_in_q <= 1'b0;
            soft_in_q  <= 1'b0;
            hard_evt_q <= 1'b0;
            soft_evt_q <= 1'b0;
        end else begin
            hard_in_q  <= req_hard;
            mount_in_q <= req_mount;
            soft_in_q  <= req_soft;
            hard_evt_q <= (req_hard & ~hard_in_q) | (req_mount & ~mount_in_q & mount_rst_en);
            soft_evt_q <= req_soft & ~soft_in_q;
        end
    end

    // Next-state logic: a hard event restarts from HOLD in any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        addr_d  = addr_q;
        if (hard_evt_q) begin
            state_d = HOLD;
            cnt_d   = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (soft_evt_q) state_d = SOFT;
                end
                HOLD: if (cnt_q == CW'(HOLD_CYC - 1)) begin
                    state_d = CLR_EN ? CLEAR : POST;
                    cnt_d   = '0;
                end
                CLEAR: begin
                    cnt_d = '0;
                    if (clr_ack) begin
                        if (&addr_q) state_d = POST;
                        else addr_d = addr_q + 1'b1;
                    end
                end
                POST: if (cnt_q == CW'(POST_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                SOFT: if (cnt_q == CW'(SOFT_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            addr_q       <= '0;
            hard_reset_q <= 1'b1;
            soft_reset_q <= 1'b0;
            clr_we_q     <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            hard_reset_q <= state_d inside {HOLD, CLEAR, POST};
            soft_reset_q <= state_d == SOFT;
            clr_we_q     <= state_d == CLEAR;
            busy_q       <= state_d != IDLE;
        end
    end

    assign hard_reset = hard_reset_q;
    assign soft_reset = soft_reset_q;
    assign clr_we     = clr_we_q;
    assign clr_addr   = addr_q;
    assign clr_data   = CLR_VAL;
    assign busy       = busy_q;
endmodule

// File: tb/tb_zxn_reset_seq.sv
// tb_zxn_reset_seq: directed and random checks of zxn_reset_seq against a countdown model
module tb_zxn_reset_seq;
    localparam int AW   = 4;
    localparam int NA   = 1 << AW;
    localparam int HOLD = 4;
    localparam int POST = 3;
    localparam int SOFT = 5;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_hard = 1'b0, req_mount = 1'b0, mount_rst_en = 1'b0, req_soft = 1'b0;
    logic          clr_ack = 1'b1;
    logic          hard_reset, soft_reset, clr_we, busy;
    logic [AW-1:0] clr_addr;
    logic [7:0]    clr_data;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_mode = 0;
    int cyc = 0;

    // model: remaining cycles of each phase plus the pending (one-cycle delayed) events
    int m_hold, m_post, m_soft, m_addr;
    bit m_clr, m_ph, m_ps, p_h, p_m, p_s, m_rst;

    // observed activity, only written by the compare process
    int hard_cnt = 0, soft_cnt = 0, busy_cnt = 0;
    int wq[$];

    zxn_reset_seq #(.AW(AW), .CLR_VAL(8'hFF), .HOLD_CYC(HOLD), .POST_CYC(POST),
                    .SOFT_CYC(SOFT), .CLR_EN(1'b1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .req_hard(req_hard), .req_mount(req_mount),
        .mount_rst_en(mount_rst_en), .req_soft(req_soft), .clr_ack(clr_ack),
        .hard_reset(hard_reset), .soft_reset(soft_reset), .clr_we(clr_we),
        .clr_addr(clr_addr), .clr_data(clr_data), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic mreset();
        m_hold = HOLD; m_post = 0; m_soft = 0; m_addr = 0; m_clr = 0;
        m_ph = 0; m_ps = 0; p_h = 0; p_m = 0; p_s = 0;
    endtask

    task automatic mstep();
        if (m_ph) begin
            m_hold = HOLD; m_clr = 0; m_addr = 0; m_post = 0; m_soft = 0;
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin m_clr = 1; m_addr = 0; end
        end else if (m_clr) begin
            if (clr_ack) begin
                if (m_addr == NA - 1) begin m_clr = 0; m_post = POST; end
                else m_addr++;
            end
        end else if (m_post > 0) m_post--;
        else if (m_soft > 0) m_soft--;
        else if (m_ps) m_soft = SOFT;
        m_ph = (req_hard && !p_h) || (req_mount && !p_m && mount_rst_en);
        m_ps = req_soft && !p_s;
        p_h = req_hard; p_m = req_mount; p_s = req_soft;
    endtask

    initial begin
        mreset();
        m_rst = 1;
        forever begin
            @(posedge clk_sys);
            if (!reset_n) begin mreset(); m_rst = 1; end
            else begin mstep(); m_rst = 0; end
        end
    end

    initial forever begin
        @(posedge clk_sys);
        #1;
        cyc++;
        clr_ack = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    end

    // compare process: every cycle the model state defines all outputs
    initial forever begin
        bit e_hard, e_soft;
        @(negedge clk_sys);
        if (reset_n || m_rst) begin
            e_hard = m_hold > 0 || m_clr || m_post > 0;
            e_soft = m_soft > 0;
            check("hard_reset", hard_reset, e_hard);
            check("soft_reset", soft_reset, e_soft);
            check("clr_we", clr_we, m_clr);
            check("busy", busy, e_hard || e_soft);
            if (m_clr) begin
                check("clr_addr", clr_addr, m_addr);
                check("clr_data", clr_data, 8'hFF);
            end
        end
        if (reset_n) begin
            hard_cnt += hard_reset;
            soft_cnt += soft_reset;
            busy_cnt += busy;
            if (clr_we && clr_ack) wq.push_back(int'(clr_addr));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk_sys); #1;
        reset_n = 0; req_hard = 0; req_mount = 0; req_soft = 0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_hard_reset", hard_reset, 1);
        check("rst_busy", busy, 1);
        check("rst_clr_we", clr_we, 0);
        check("rst_soft_reset", soft_reset, 0);
        check("rst_clr_addr", clr_addr, 0);
        @(posedge clk_sys); #1;
        reset_n = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (3) @(negedge clk_sys);
        while (busy && n < 500) begin @(negedge clk_sys); n++; end
        check("idle_reached", busy, 0);
        @(posedge clk_sys); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check_clear(input string nm, input int b);
        check({nm, "_writes"}, wq.size() - b, NA);
        if (wq.size() >= b + NA)
            for (int i = 0; i < NA; i++) check({nm, "_addr"}, wq[b + i], i);
    endtask

    initial begin
        int hb, sb, bb, wb, n, hold;
        // 1: power-up with ack tied high
        ack_mode = 0;
        hb = hard_cnt; wb = wq.size();
        do_reset();
        wait_idle();
        check("t1_hard_cycles", hard_cnt - hb, HOLD + NA + POST);
        check_clear("t1", wb);
        // 2: ack only every third cycle
        ack_mode = 1;
        wb = wq.size();
        do_reset();
        wait_idle();
        check_clear("t2", wb);
        ack_mode = 0;
        // 3: soft pulse in IDLE
        hb = hard_cnt; sb = soft_cnt; wb = wq.size();
        req_soft = 1; cycles(1); req_soft = 0;
        cycles(12);
        check("t3_soft_cycles", soft_cnt - sb, SOFT);
        check("t3_hard_cycles", hard_cnt - hb, 0);
        check("t3_writes", wq.size() - wb, 0);
        // 4: hard edge in the middle of the clear
        do_reset();
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!(clr_we && clr_addr == 9) && n < 200);
        check("t4_reached_addr9", clr_addr, 9);
        @(posedge clk_sys); #1;
        req_hard = 1;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (clr_we && n < 50);
        hold = 0;
        while (!clr_we && hold < 50) begin hold++; @(negedge clk_sys); end
        check("t4_hold_cycles", hold, HOLD);
        check("t4_restart_addr", clr_addr, 0);
        wait_idle();
        req_hard = 0;
        cycles(2);
        // 5: mount pulse gated by mount_rst_en
        bb = busy_cnt;
        mount_rst_en = 0; req_mount = 1; cycles(1); req_mount = 0;
        cycles(10);
        check("t5_disabled_busy", busy_cnt - bb, 0);
        hb = hard_cnt; wb = wq.size();
        mount_rst_en = 1; req_mount = 1; cycles(1); req_mount = 0;
        wait_idle();
        check("t5_hard_cycles", hard_cnt - hb, HOLD + NA + POST);
        check_clear("t5", wb);
        // 6: hard and soft together, then held high
        hb = hard_cnt; sb = soft_cnt;
        req_hard = 1; req_soft = 1;
        wait_idle();
        check("t6_hard_cycles", hard_cnt - hb, HOLD + NA + POST);
        check("t6_soft_cycles", soft_cnt - sb, 0);
        bb = busy_cnt;
        cycles(30);
        check("t6_held_busy", busy_cnt - bb, 0);
        req_hard = 0; req_soft = 0;
        cycles(2);
        // 7: random requests and acks against the model
        ack_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) req_hard = ~req_hard;
            if ($urandom_range(0, 19) == 0) req_soft = ~req_soft;
            if ($urandom_range(0, 39) == 0) req_mount = ~req_mount;
            if ($urandom_range(0, 49) == 0) mount_rst_en = ~mount_rst_en;
            cycles(1);
        end
        req_hard = 0; req_soft = 0; req_mount = 0;
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
